// File: rtl/sixty_four_adder_pkg.sv
// Shared constants for the registered WIDTH-bit adder.
// Optional build macro used by this block: CARRY_SELECT_EN.
package sixty_four_adder_pkg;

  // Default operand/sum width in bits.
  localparam int WIDTH_DEF = 64;

  // Default bit index where the carry-select upper block starts.
  localparam int SPLIT_DEF = 32;

endpackage : sixty_four_adder_pkg

// File: rtl/ripple_block_adder.sv
// N-bit ripple-carry adder built from per-bit full-adder logic.
// The carry is walked LSB to MSB; each bit is one full adder.
module ripple_block_adder #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  // Full-adder chain: sum bit from the three-input xor, carry from generate/propagate.
  always_comb begin
    logic carry;
    carry = cin;
    sum   = '0;
    for (int i = 0; i < N; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule : ripple_block_adder

// File: rtl/sixty_four_bit_adder_core.sv
// Combinational sum path of the adder, built only from ripple_block_adder
// instances and a 2:1 select.
// Build macro: CARRY_SELECT_EN -- defined gives a carry-select split at SPLIT,
// undefined gives one WIDTH-bit ripple chain. Results are identical either way.
module sixty_four_bit_adder_core
  import sixty_four_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SPLIT = SPLIT_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Reject an upper block that would be empty or cover the whole word.
  if (SPLIT < 1 || SPLIT > WIDTH - 1) begin : g_split_check
    $error("SPLIT must lie in 1..WIDTH-1");
  end

`ifdef CARRY_SELECT_EN

  localparam int HI_W = WIDTH - SPLIT;

  logic [SPLIT-1:0] lo_sum;
  logic             lo_cout;
  logic [HI_W-1:0]  hi_sum0;
  logic [HI_W-1:0]  hi_sum1;
  logic             hi_cout0;
  logic             hi_cout1;

  ripple_block_adder #(.N(SPLIT)) u_lo (
    .a    (a[SPLIT-1:0]),
    .b    (b[SPLIT-1:0]),
    .cin  (cin),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  // Upper block speculated for both possible carries out of the lower block.
  ripple_block_adder #(.N(HI_W)) u_hi0 (
    .a    (a[WIDTH-1:SPLIT]),
    .b    (b[WIDTH-1:SPLIT]),
    .cin  (1'b0),
    .sum  (hi_sum0),
    .cout (hi_cout0)
  );

  ripple_block_adder #(.N(HI_W)) u_hi1 (
    .a    (a[WIDTH-1:SPLIT]),
    .b    (b[WIDTH-1:SPLIT]),
    .cin  (1'b1),
    .sum  (hi_sum1),
    .cout (hi_cout1)
  );

  // Lower-block carry picks the matching upper result.
  always_comb begin
    sum[SPLIT-1:0] = lo_sum;
    if (lo_cout) begin
      sum[WIDTH-1:SPLIT] = hi_sum1;
      cout               = hi_cout1;
    end else begin
      sum[WIDTH-1:SPLIT] = hi_sum0;
      cout               = hi_cout0;
    end
  end

`else

  ripple_block_adder #(.N(WIDTH)) u_full (
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

`endif

endmodule : sixty_four_bit_adder_core

// File: rtl/sixty_four_bit_adder.sv
// Registered WIDTH-bit unsigned adder, one cycle latency, no backpressure.
// {Cout,S} = A + B + Cin; outputs hold when no new operands arrive.
// Build macro: CARRY_SELECT_EN selects the carry-select sum path in the core.
module sixty_four_bit_adder
  import sixty_four_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SPLIT = SPLIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  logic [WIDTH-1:0] sum_p0;
  logic             cout_p0;
  logic [WIDTH-1:0] sum_p1;
  logic             cout_p1;
  logic             vld_p1;

  sixty_four_bit_adder_core #(
    .WIDTH (WIDTH),
    .SPLIT (SPLIT)
  ) u_core (
    .a    (A),
    .b    (B),
    .cin  (Cin),
    .sum  (sum_p0),
    .cout (cout_p0)
  );

  // ---- stage p0 -> p1: capture the sum on accepted operands, otherwise hold ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      sum_p1  <= '0;
      cout_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        sum_p1  <= sum_p0;
        cout_p1 <= cout_p0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign S         = sum_p1;
  assign Cout      = cout_p1;

endmodule : sixty_four_bit_adder

// File: tb/tb_sixty_four_bit_adder.sv
// Scoreboard bench for sixty_four_bit_adder: stimulus pushes expected sums,
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_sixty_four_bit_adder;

  localparam int W = 64;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         out_valid;
  logic [W-1:0] S;
  logic         Cout;

  logic [W:0]   exp_q[$];
  logic [W:0]   held_exp;
  int           total;
  int           bad;

  sixty_four_bit_adder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .out_valid (out_valid),
    .S         (S),
    .Cout      (Cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    logic [W:0] r;
    r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    return r;
  endfunction

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got Cout=%0h S=%h, expected Cout=%0h S=%h",
               name, act[W], act[W-1:0], req[W], req[W-1:0]);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c);
    @(posedge clk);
    #1;
    in_valid = v;
    A        = a;
    B        = b;
    Cin      = c;
    if (v) exp_q.push_back(ref_add(a, b, c));
  endtask

  // Monitor: reset values, popped results on out_valid, held values otherwise.
  initial begin
    held_exp = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("reset_sum", {Cout, S}, '0);
        check("reset_valid", {{W{1'b0}}, out_valid}, '0);
      end else if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", {{W{1'b0}}, out_valid}, '0);
        end else begin
          held_exp = exp_q.pop_front();
          check("result", {Cout, S}, held_exp);
        end
      end else begin
        check("hold", {Cout, S}, held_exp);
      end
    end
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    A        = '0;
    B        = '0;
    Cin      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed vectors, including the split-carry and wrap-around cases.
    drive(1'b1, 64'h0000200200100100, 64'hAAAAAAAAAAAAAAAA, 1'b0);
    drive(1'b1, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1);
    drive(1'b1, 64'h00000000FFFFFFFF, 64'h1, 1'b0);
    drive(1'b1, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1);
    drive(1'b0, 64'h123456789ABCDEF0, 64'h0FEDCBA987654321, 1'b1);
    drive(1'b0, 64'h0, 64'h0, 1'b0);
    drive(1'b1, 64'h00000000FFFFFFFF, 64'h0, 1'b1);
    drive(1'b1, 64'h7FFFFFFFFFFFFFFF, 64'h1, 1'b0);
    drive(1'b0, 64'h0, 64'h0, 1'b0);

    // Reset between a valid input and its output edge discards the result.
    drive(1'b1, 64'h1111111111111111, 64'h2222222222222222, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_sum", {Cout, S}, '0);
    check("async_reset_valid", {{W{1'b0}}, out_valid}, '0);
    exp_q.delete();
    held_exp = '0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 64'h0, 64'h0, 1'b0);
    drive(1'b0, 64'h0, 64'h0, 1'b0);
    drive(1'b1, 64'h00000000FFFFFFFF, 64'h1, 1'b0);
    drive(1'b0, 64'h0, 64'h0, 1'b0);

    // Random back-to-back traffic.
    for (int i = 0; i < 10000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 7 == 0) rb = ~ra;
      drive(1'b1, ra, rb, 1'($urandom_range(0, 1)));
    end
    drive(1'b0, 64'h0, 64'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("drain_empty", (W + 1)'(exp_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sixty_four_bit_adder

// File: doc/sixty_four_bit_adder.md
SIXTY_FOUR_BIT_ADDER -- requirements
Module: sixty_four_bit_adder

Interface
REQ-001 Parameter WIDTH, default 64: operand and sum width in bits.
REQ-002 Parameter SPLIT, default 32: bit index where the carry-select upper block starts; legal range 1..WIDTH-1.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in_valid  input  1  A, B and Cin are valid this cycle.
REQ-007 A  input  WIDTH  first operand, unsigned.
REQ-008 B  input  WIDTH  second operand, unsigned.
REQ-009 Cin  input  1  carry in.
REQ-010 out_valid  output  1  S and Cout hold a new result.
REQ-011 S  output  WIDTH  registered sum, bits WIDTH-1..0.
REQ-012 Cout  output  1  registered carry out of bit WIDTH-1.

Function
REQ-013 {Cout,S} SHALL equal A + B + Cin computed at WIDTH+1 bits, unsigned, with no saturation; overflow appears only in Cout.
REQ-014 Latency SHALL be exactly 1 cycle: operands sampled on the rising edge where in_valid=1 appear on S/Cout after that edge, with out_valid=1.
REQ-015 On an edge with in_valid=0, S and Cout SHALL hold their previous values and out_valid SHALL be 0.
REQ-016 Back-to-back in_valid SHALL be accepted every cycle with no stall; there is no backpressure input.
REQ-017 Wrap-around: all-ones + 0 + Cin=1 SHALL give S=0, Cout=1.
REQ-018 A carry generated in bit SPLIT-1 SHALL propagate correctly into bit SPLIT in the same cycle.

Reset
REQ-019 While rst=1, S=0, Cout=0 and out_valid=0, asynchronously and regardless of clk.
REQ-020 Reset asserted while a result is pending SHALL discard that result; the first out_valid after reset release SHALL follow the first in_valid sampled after release.

Configuration
REQ-021 Macro CARRY_SELECT_EN defined: the lower SPLIT bits SHALL be one ripple block; the upper WIDTH-SPLIT bits SHALL be computed twice (carry-in 0 and 1) and selected by the lower block's carry out.
REQ-022 Macro CARRY_SELECT_EN undefined: a single WIDTH-bit ripple-carry chain SHALL be used.
REQ-023 S, Cout, out_valid and latency SHALL be bit-identical with and without CARRY_SELECT_EN.

Structure
REQ-024 Package sixty_four_adder_pkg SHALL hold the WIDTH and SPLIT default constants.
REQ-025 Sub-module ripple_block_adder SHALL implement a parameterised N-bit ripple adder with carry in and carry out, built from per-bit full-adder logic.
REQ-026 Both configurations SHALL be built only from ripple_block_adder instances plus a 2:1 select; the top level SHALL contain only the registers.

Verification
REQ-027 A=0x0000200200100100, B=0xAAAAAAAAAAAAAAAA, Cin=0, in_valid=1 -> next cycle S=0xAAAACAACAABAABAA, Cout=0, out_valid=1.
REQ-028 A=0xFFFFFFFFFFFFFFFF, B=0, Cin=1 -> S=0, Cout=1.
REQ-029 A=0x00000000FFFFFFFF, B=1, Cin=0 -> S=0x0000000100000000, Cout=0; this checks the carry across the split.
REQ-030 A=B=0xFFFFFFFFFFFFFFFF, Cin=1 -> S=0xFFFFFFFFFFFFFFFF, Cout=1; the next cycle with in_valid=0 -> values held and out_valid=0.
REQ-031 Assert rst between a valid input and its output edge -> S=0, Cout=0, out_valid=0 immediately, and no stale result after release.
REQ-032 10,000 random A, B and Cin with in_valid=1 every cycle, run in both CARRY_SELECT_EN builds -> every result matches a behavioural + reference, one cycle later.
